// File: rtl/doodle_jump_ctrl.sv
// Doodle jump controller: owns the doodle position, runs the I/UP/DOWN/DONE jump cycle on Tick,
// resolves landings against a runtime platform table and requests world scrolling.
module doodle_jump_ctrl #(
    parameter int NUM_PLAT      = 12,
    parameter int COORD_W       = 10,
    parameter int JUMP_HEIGHT   = 120,
    parameter int DOODLE_RADIUS = 13,
    parameter int PLAT_W        = 64,
    parameter int LAND_TOL      = 10,
    parameter int X_MIN         = 144,
    parameter int X_MAX         = 774,
    parameter int Y_BOTTOM      = 515,
    parameter int SCROLL_LINE   = 275,
    parameter int X_INIT        = 459,
    parameter int Y_INIT        = 480,
    parameter int SCORE_W       = 16,
    localparam int HIT_W        = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         Start,
    input  logic                         Ack,
    input  logic                         Tick,
    input  logic                         Left,
    input  logic                         Right,
    input  logic [NUM_PLAT*COORD_W-1:0]  plat_x,
    input  logic [NUM_PLAT*COORD_W-1:0]  plat_y,
    input  logic [NUM_PLAT-1:0]          plat_valid,
    output logic                         q_I,
    output logic                         q_Up,
    output logic                         q_Down,
    output logic                         q_Done,
    output logic [COORD_W-1:0]           doodle_x,
    output logic [COORD_W-1:0]           doodle_y,
    output logic [COORD_W-1:0]           up_count,
    output logic                         scroll_pulse,
    output logic [SCORE_W-1:0]           scroll_total,
    output logic                         hit_pulse,
    output logic [HIT_W-1:0]             hit_index
);

    localparam int CW1 = COORD_W + 1;

    localparam logic [COORD_W-1:0] ONE_C    = COORD_W'(1);
    localparam logic [COORD_W-1:0] XMIN_C   = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] XMAX_C   = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] XINIT_C  = COORD_W'(X_INIT);
    localparam logic [COORD_W-1:0] YINIT_C  = COORD_W'(Y_INIT);
    localparam logic [COORD_W-1:0] JH_C     = COORD_W'(JUMP_HEIGHT);
    localparam logic [COORD_W-1:0] SLINE_C  = COORD_W'(SCROLL_LINE);
    localparam logic [CW1-1:0]     RAD_E    = CW1'(DOODLE_RADIUS);
    localparam logic [CW1-1:0]     PW_E     = CW1'(PLAT_W);
    localparam logic [CW1-1:0]     TOL_E    = CW1'(LAND_TOL);
    localparam logic [CW1-1:0]     BOT_E    = CW1'(Y_BOTTOM);
    localparam logic [SCORE_W-1:0] SONE_C   = SCORE_W'(1);

    typedef enum logic [3:0] {
        S_I    = 4'b0001,
        S_UP   = 4'b0010,
        S_DOWN = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    state_t               state_reg;
    logic [COORD_W-1:0]   doodle_x_reg, doodle_y_reg, up_count_reg;
    logic [SCORE_W-1:0]   scroll_total_reg;
    logic                 scroll_pulse_reg, hit_pulse_reg;
    logic [HIT_W-1:0]     hit_index_reg;

    logic [COORD_W-1:0]   x_next;
    logic [NUM_PLAT-1:0]  hit_vec;
    logic [HIT_W-1:0]     hit_index_next;
    logic                 any_hit;
    logic [CW1-1:0]       dx_e, dy_e;

    // One extra bit of headroom lets every landing bound be formed by addition only.
    assign dx_e = {1'b0, doodle_x_reg};
    assign dy_e = {1'b0, doodle_y_reg};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAT; gi++) begin : g_hit
            logic [CW1-1:0] px_e, py_e;
            assign px_e = {1'b0, plat_x[gi*COORD_W +: COORD_W]};
            assign py_e = {1'b0, plat_y[gi*COORD_W +: COORD_W]};
            assign hit_vec[gi] = plat_valid[gi]
                              && (dx_e + RAD_E >= px_e)
                              && (dx_e <= px_e + PW_E + RAD_E)
                              && (dy_e + RAD_E >= py_e)
                              && (dy_e + RAD_E <= py_e + TOL_E);
        end
    endgenerate

    // Lowest-numbered platform wins when several overlap the landing window.
    always_comb begin
        hit_index_next = '0;
        for (int i = NUM_PLAT - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_index_next = HIT_W'(i);
        end
    end

    assign any_hit = |hit_vec;

    always_comb begin
        x_next = doodle_x_reg;
        if (Left && !Right)
            x_next = (doodle_x_reg == XMIN_C) ? XMAX_C : doodle_x_reg - ONE_C;
        else if (Right && !Left)
            x_next = (doodle_x_reg == XMAX_C) ? XMIN_C : doodle_x_reg + ONE_C;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg        <= S_I;
            doodle_x_reg     <= XINIT_C;
            doodle_y_reg     <= YINIT_C;
            up_count_reg     <= '0;
            scroll_total_reg <= '0;
            scroll_pulse_reg <= 1'b0;
            hit_pulse_reg    <= 1'b0;
            hit_index_reg    <= '0;
        end else begin
            scroll_pulse_reg <= 1'b0;
            hit_pulse_reg    <= 1'b0;
            case (state_reg)
                S_I: begin
                    if (Start) begin
                        state_reg        <= S_UP;
                        doodle_x_reg     <= XINIT_C;
                        doodle_y_reg     <= YINIT_C;
                        up_count_reg     <= '0;
                        scroll_total_reg <= '0;
                    end
                end
                S_UP: begin
                    if (Tick) begin
                        doodle_x_reg <= x_next;
                        if (up_count_reg >= JH_C) begin
                            state_reg <= S_DOWN;
                        end else begin
                            up_count_reg <= up_count_reg + ONE_C;
                            // At the scroll line the world moves instead of the doodle.
                            if (doodle_y_reg > SLINE_C) begin
                                doodle_y_reg <= doodle_y_reg - ONE_C;
                            end else begin
                                scroll_pulse_reg <= 1'b1;
                                if (scroll_total_reg != '1)
                                    scroll_total_reg <= scroll_total_reg + SONE_C;
                            end
                        end
                    end
                end
                S_DOWN: begin
                    if (Tick) begin
                        doodle_x_reg <= x_next;
                        if (dy_e + RAD_E >= BOT_E) begin
                            state_reg <= S_DONE;
                        end else if (any_hit) begin
                            state_reg     <= S_UP;
                            up_count_reg  <= '0;
                            hit_pulse_reg <= 1'b1;
                            hit_index_reg <= hit_index_next;
                        end else begin
                            doodle_y_reg <= doodle_y_reg + ONE_C;
                        end
                    end
                end
                S_DONE: begin
                    if (Ack) state_reg <= S_I;
                end
                default: state_reg <= S_I;
            endcase
        end
    end

    assign q_I          = state_reg[0];
    assign q_Up         = state_reg[1];
    assign q_Down       = state_reg[2];
    assign q_Done       = state_reg[3];
    assign doodle_x     = doodle_x_reg;
    assign doodle_y     = doodle_y_reg;
    assign up_count     = up_count_reg;
    assign scroll_pulse = scroll_pulse_reg;
    assign scroll_total = scroll_total_reg;
    assign hit_pulse    = hit_pulse_reg;
    assign hit_index    = hit_index_reg;

endmodule

// File: tb/tb_doodle_jump_ctrl.sv
// Scoreboard bench for doodle_jump_ctrl: a behavioural model queues the expected outputs for
// every driven cycle, and they are popped and compared once the DUT has clocked.
module tb_doodle_jump_ctrl;

    localparam int NP = 12;
    localparam int CW = 10;

    logic              Clk = 1'b0;
    logic              Reset_n, Start, Ack, Tick, Left, Right;
    logic [NP*CW-1:0]  plat_x, plat_y;
    logic [NP-1:0]     plat_valid;
    logic              q_I, q_Up, q_Down, q_Done;
    logic [CW-1:0]     doodle_x, doodle_y, up_count;
    logic              scroll_pulse, hit_pulse;
    logic [15:0]       scroll_total;
    logic [3:0]        hit_index;

    doodle_jump_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Ack(Ack), .Tick(Tick),
        .Left(Left), .Right(Right), .plat_x(plat_x), .plat_y(plat_y),
        .plat_valid(plat_valid), .q_I(q_I), .q_Up(q_Up), .q_Down(q_Down),
        .q_Done(q_Done), .doodle_x(doodle_x), .doodle_y(doodle_y),
        .up_count(up_count), .scroll_pulse(scroll_pulse),
        .scroll_total(scroll_total), .hit_pulse(hit_pulse), .hit_index(hit_index)
    );

    always #5 Clk = ~Clk;

    int px[NP], py[NP];
    bit pv[NP];

    always_comb begin
        plat_x     = '0;
        plat_y     = '0;
        plat_valid = '0;
        for (int i = 0; i < NP; i++) begin
            plat_x[i*CW +: CW] = CW'(px[i]);
            plat_y[i*CW +: CW] = CW'(py[i]);
            plat_valid[i]      = pv[i];
        end
    end

    typedef struct {
        int oh; int x; int y; int up; int tot; int hit; int hidx; int scr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0;
    int   n_scroll_obs = 0, n_hit_obs = 0;

    // Model state: 0=I 1=UP 2=DOWN 3=DONE
    int m_state, m_x, m_y, m_up, m_tot, m_hidx, m_hit, m_scr;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_x = 459; m_y = 480; m_up = 0; m_tot = 0;
        m_hidx = 0; m_hit = 0; m_scr = 0;
    endtask

    task automatic model_step(input bit st, input bit ak, input bit tk, input bit l, input bit r);
        int ox, nx;
        bit found;
        m_hit = 0; m_scr = 0;
        ox = m_x; nx = ox; found = 0;
        if (l && !r)      nx = (ox == 144) ? 774 : ox - 1;
        else if (r && !l) nx = (ox == 774) ? 144 : ox + 1;
        case (m_state)
            0: if (st) begin
                m_state = 1; m_x = 459; m_y = 480; m_up = 0; m_tot = 0;
            end
            1: if (tk) begin
                m_x = nx;
                if (m_up >= 120) m_state = 2;
                else begin
                    m_up++;
                    if (m_y > 275) m_y--;
                    else begin
                        m_scr = 1;
                        if (m_tot < 65535) m_tot++;
                    end
                end
            end
            2: if (tk) begin
                m_x = nx;
                if (m_y + 13 >= 515) m_state = 3;
                else begin
                    for (int i = 0; i < NP; i++) begin
                        if (!found && pv[i] && ox + 13 >= px[i] && ox <= px[i] + 77 &&
                            m_y + 13 >= py[i] && m_y + 13 <= py[i] + 10) begin
                            found  = 1;
                            m_hidx = i;
                        end
                    end
                    if (found) begin
                        m_state = 1; m_up = 0; m_hit = 1;
                    end else m_y++;
                end
            end
            default: if (ak) m_state = 0;
        endcase
    endtask

    task automatic cycle(input bit st, input bit ak, input bit tk, input bit l, input bit r);
        exp_t e;
        Start = st; Ack = ak; Tick = tk; Left = l; Right = r;
        model_step(st, ak, tk, l, r);
        e.oh = 8 >> m_state; e.x = m_x; e.y = m_y; e.up = m_up; e.tot = m_tot;
        e.hit = m_hit; e.hidx = m_hidx; e.scr = m_scr;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        check("state",  int'({q_I, q_Up, q_Down, q_Done}), e.oh);
        check("x",      int'(doodle_x), e.x);
        check("y",      int'(doodle_y), e.y);
        check("up",     int'(up_count), e.up);
        check("total",  int'(scroll_total), e.tot);
        check("hit",    int'(hit_pulse), e.hit);
        check("hidx",   int'(hit_index), e.hidx);
        check("scroll", int'(scroll_pulse), e.scr);
        if (scroll_pulse) n_scroll_obs++;
        if (hit_pulse)    n_hit_obs++;
        $display("[%0t] in s=%b a=%b t=%b l=%b r=%b | st=%b x=%0d y=%0d up=%0d tot=%0d hit=%b/%0d scr=%b",
                 $time, st, ak, tk, l, r, {q_I, q_Up, q_Down, q_Done}, doodle_x, doodle_y,
                 up_count, scroll_total, hit_pulse, hit_index, scroll_pulse);
    endtask

    task automatic ticks(input int n, input bit l, input bit r);
        for (int i = 0; i < n; i++) cycle(0, 0, 1, l, r);
    endtask

    task automatic run_until_done(input string tag);
        int n = 0;
        while (m_state != 3 && n < 1000) begin
            cycle(0, 0, 1, 0, 0);
            n++;
        end
        check({tag, "_bound"}, int'(n < 1000), 1);
    endtask

    task automatic run_until_hit(input string tag);
        int n = 0;
        do begin
            cycle(0, 0, 1, 0, 0);
            n++;
        end while (m_hit == 0 && m_state != 3 && n < 1000);
        check({tag, "_landed"}, m_hit, 1);
    endtask

    initial begin
        Reset_n = 1'b0; Start = 0; Ack = 0; Tick = 0; Left = 0; Right = 0;
        for (int i = 0; i < NP; i++) begin px[i] = 0; py[i] = 0; pv[i] = 0; end
        model_reset();
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;

        check("rst_qI", int'(q_I), 1);
        check("rst_onehot", int'({q_Up, q_Down, q_Done}), 0);
        check("rst_x", int'(doodle_x), 459);
        check("rst_y", int'(doodle_y), 480);
        check("rst_up", int'(up_count), 0);
        check("rst_total", int'(scroll_total), 0);
        check("rst_hidx", int'(hit_index), 0);
        check("rst_pulses", int'({hit_pulse, scroll_pulse}), 0);

        // Game 1: full rise with idle cycles interleaved, then async reset mid-fall.
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 120; i++) begin
            cycle(0, 0, 1, 0, 0);
            if (i % 7 == 0) cycle(0, 0, 0, 0, 0);
        end
        check("rise_y", int'(doodle_y), 360);
        check("rise_up", int'(up_count), 120);
        cycle(0, 0, 1, 0, 0);
        check("top_qDown", int'(q_Down), 1);
        check("top_y", int'(doodle_y), 360);
        ticks(5, 0, 0);
        #2 Reset_n = 1'b0;
        #1;
        check("arst_qI", int'(q_I), 1);
        check("arst_x", int'(doodle_x), 459);
        check("arst_y", int'(doodle_y), 480);
        check("arst_total", int'(scroll_total), 0);
        model_reset();
        @(posedge Clk);
        #1 Reset_n = 1'b1;

        // Game 2a: platform 3 disabled, doodle falls through to the bottom.
        px[3] = 430; py[3] = 400; pv[3] = 0;
        n_hit_obs = 0;
        cycle(1, 0, 0, 0, 0);
        ticks(121, 0, 0);
        run_until_done("fall");
        check("fall_nohit", n_hit_obs, 0);
        check("fall_y", int'(doodle_y), 502);
        check("fall_qDone", int'(q_Done), 1);
        cycle(1, 0, 1, 0, 0);
        cycle(1, 0, 1, 1, 0);
        check("done_hold", int'(q_Done), 1);
        cycle(0, 1, 0, 0, 0);
        check("ack_qI", int'(q_I), 1);

        // Game 2b: land on platform 3, then on overlapping 2 and 5, then scroll.
        pv[3] = 1;
        cycle(1, 0, 0, 0, 0);
        ticks(121, 0, 0);
        run_until_hit("p3");
        check("p3_hit", int'(hit_pulse), 1);
        check("p3_hidx", int'(hit_index), 3);
        check("p3_qUp", int'(q_Up), 1);
        check("p3_up", int'(up_count), 0);
        check("p3_y", int'(doodle_y), 387);
        ticks(121, 0, 0);
        px[2] = 430; py[2] = 313; pv[2] = 1;
        px[5] = 420; py[5] = 313; pv[5] = 1;
        run_until_hit("p25");
        check("p25_hidx", int'(hit_index), 2);
        check("p25_y", int'(doodle_y), 300);
        n_scroll_obs = 0;
        ticks(121, 0, 0);
        check("scroll_count", n_scroll_obs, 95);
        check("scroll_y", int'(doodle_y), 275);
        check("scroll_qDown", int'(q_Down), 1);
        for (int i = 0; i < NP; i++) pv[i] = 0;
        run_until_done("fall2");
        cycle(0, 1, 0, 0, 0);

        // Game 3: steer right until the right edge, then exercise both wraps.
        px[0] = 600; py[0] = 400; pv[0] = 1;
        cycle(1, 0, 0, 0, 0);
        begin
            int n = 0;
            while (m_x != 774 && m_state != 3 && n < 1000) begin
                cycle(0, 0, 1, 0, 1);
                n++;
            end
        end
        check("edge_x", int'(doodle_x), 774);
        cycle(0, 0, 1, 0, 1);
        check("wrap_right", int'(doodle_x), 144);
        cycle(0, 0, 1, 1, 0);
        check("wrap_left", int'(doodle_x), 774);
        cycle(0, 0, 1, 1, 1);
        check("both_hold", int'(doodle_x), 774);
        cycle(0, 0, 1, 0, 0);
        check("none_hold", int'(doodle_x), 774);
        run_until_done("fall3");
        cycle(0, 1, 0, 0, 0);
        check("end_qI", int'(q_I), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/doodle_jump_ctrl.md
Name: doodle_jump_ctrl

Overview:
Parametrised successor to the doodle jump state machine. It owns the doodle's position, runs the I/UP/DOWN/DONE jump cycle on a movement tick, and resolves landings against a runtime platform table of NUM_PLAT entries instead of fixed constants. It adds horizontal steering with screen wrap and generates scroll requests when the doodle climbs past the scroll line. It sits between the input debouncers/tick generator and the VGA platform/sprite renderer.

Parameters:
NUM_PLAT, 12, number of platform table entries
COORD_W, 10, width of all coordinates and counters
JUMP_HEIGHT, 120, ticks of upward travel per jump
DOODLE_RADIUS, 13, centre-to-edge distance of the doodle
PLAT_W, 64, platform width in pixels, measured from the left edge plat_x
LAND_TOL, 10, vertical landing window below the platform top
X_MIN, 144, leftmost doodle centre x; X_MAX, 774, rightmost
Y_BOTTOM, 515, screen bottom line; SCROLL_LINE, 275, upper bound of doodle_y
X_INIT, 459, start x; Y_INIT, 480, start y
SCORE_W, 16, width of scroll_total

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
Start  in  1  leave I and begin a game
Ack  in  1  leave DONE
Tick  in  1  one-cycle movement strobe; all motion happens only on Tick cycles
Left, Right  in  1 each  steering levels
plat_x  in  NUM_PLAT*COORD_W  platform left edges, entry i at bits [i*COORD_W +: COORD_W]
plat_y  in  NUM_PLAT*COORD_W  platform top edges, same packing
plat_valid  in  NUM_PLAT  entry enable
q_I, q_Up, q_Down, q_Done  out  1 each  one-hot state
doodle_x, doodle_y  out  COORD_W  doodle centre
up_count  out  COORD_W  ticks of upward travel in the current jump
scroll_pulse  out  1  one-cycle pulse: world scrolls down one pixel
scroll_total  out  SCORE_W  accumulated scroll, saturating
hit_pulse  out  1  one-cycle pulse on landing
hit_index  out  clog2(NUM_PLAT)  index of the platform landed on, held until the next hit

Behaviour:
- Reset (async, Reset_n=0): state=I; doodle_x=X_INIT; doodle_y=Y_INIT; up_count=0; scroll_total=0; hit_index=0; pulses=0.
- Pulses default to 0 on every cycle they are not set.
- I: Start=1 -> UP on the next edge (Tick not required); load doodle_x=X_INIT, doodle_y=Y_INIT, up_count=0, scroll_total=0.
- UP, Tick=1: if up_count>=JUMP_HEIGHT -> DOWN, no vertical move that tick. Otherwise up_count+1; if doodle_y>SCROLL_LINE then doodle_y-1, else doodle_y is held, scroll_pulse=1, and scroll_total+1 (saturates at all-ones).
- DOWN, Tick=1, checked in priority order:
  (1) doodle_y+DOODLE_RADIUS>=Y_BOTTOM -> DONE, no move.
  (2) any landing hit -> UP, up_count=0, hit_pulse=1, hit_index=lowest hit index, no vertical move.
  (3) otherwise doodle_y+1.
- Landing hit for entry i: plat_valid[i] && doodle_x+DOODLE_RADIUS>=plat_x && doodle_x<=plat_x+PLAT_W+DOODLE_RADIUS && doodle_y+DOODLE_RADIUS>=plat_y && doodle_y+DOODLE_RADIUS<=plat_y+LAND_TOL.
- Landing arithmetic is done at COORD_W+1 bits with no subtraction, so there is no underflow.
- Landing is evaluated combinationally on the current registered position.
- Horizontal move, UP/DOWN on Tick, applied in the same tick as vertical:
  - Left&&!Right: x-1, or X_MAX if x==X_MIN.
  - Right&&!Left: x+1, or X_MIN if x==X_MAX.
  - Both or neither: hold.
- Horizontal steering is also applied on the terminating tick (UP->DOWN, DOWN->DONE, landing).
- DONE: position, scroll_total and up_count hold; Ack=1 -> I on the next edge. Tick and Start are ignored.
- Start in UP/DOWN, and Ack outside DONE, are ignored.
- Tick=0: no state or position change, except I->UP and DONE->I.
- Illegal state encoding -> I on the next edge.
- The block does not move platforms; the renderer consumes scroll_pulse.

Test Plan:
- Reset mid-DOWN (Reset_n low one cycle) -> q_I=1, doodle_x=459, doodle_y=480, scroll_total=0, asynchronously before the next edge.
- Start, then 120 Ticks with no input -> doodle_y=360, up_count=120; Tick 121 -> q_Down=1, doodle_y=360.
- Platform 3 at (430,400), valid; doodle falling at x=459 -> on the Tick where doodle_y+13=400: hit_pulse=1, hit_index=3, q_Up=1, up_count=0. Same geometry with plat_valid[3]=0 -> falls through.
- Platforms 2 and 5 overlap the landing window -> hit_index=2.
- Jump from y=300 with JUMP_HEIGHT=120 -> y reaches 275 after 25 ticks, then 95 scroll_pulses, scroll_total=95, y stays 275.
- Right held at x=774 on a Tick -> x=144; Left at 144 -> 774; both held -> x unchanged.
- No platforms, fall to y=502 -> next Tick gives q_Done=1; Tick/Start ignored; Ack -> q_I=1.
